// File: rtl/micro_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// micro_sequencer_pkg
// Definitions shared by the instruction decoder and the micro sequencer:
//   - phase (state) encodings
//   - microinstruction control-bit indices and operand field ranges
//   - PCSrc encodings
// ----------------------------------------------------------------------------
package micro_sequencer_pkg;

    // Phase encodings as seen on the State output.
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // PC source selection.
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target

    // Phase-selection bits.
    localparam int UI_ALU_USE   = 31;
    localparam int UI_MEM_ACC   = 30;
    localparam int UI_WB_USE    = 29;

    // Operand fields (consumed by the datapath, not by the sequencer).
    localparam int UI_ALUOP_HI  = 28;
    localparam int UI_ALUOP_LO  = 25;
    localparam int UI_RS_HI     = 24;
    localparam int UI_RS_LO     = 20;
    localparam int UI_RT_HI     = 19;
    localparam int UI_RT_LO     = 15;
    localparam int UI_RD_HI     = 14;
    localparam int UI_RD_LO     = 10;

    // Control bits.
    localparam int UI_ALUB_REG  = 0;
    localparam int UI_IMM       = 1;
    localparam int UI_REG_WRITE = 2;
    localparam int UI_MEM2REG   = 3;
    localparam int UI_MEM_WRITE = 4;
    localparam int UI_MEM_READ  = 5;
    localparam int UI_JUMP      = 6;
    localparam int UI_BRANCH    = 7;
    localparam int UI_HALT      = 8;

    // Extract the ALU opcode field of a microinstruction.
    function automatic logic [3:0] ui_alu_op(input logic [31:0] ui);
        return ui[UI_ALUOP_HI:UI_ALUOP_LO];
    endfunction

endpackage

// File: rtl/micro_sequencer_next_state.sv
// ----------------------------------------------------------------------------
// micro_next_state
// Combinational next-phase and datapath-strobe logic of the micro sequencer.
// Ports:
//   state_i          current phase register
//   reset_i          synchronous reset; forces every strobe inactive
//   micro_instruct_i live microinstruction (decoded only in ID)
//   uq_i             latched microinstruction (decoded in EXE/MEM/WB)
//   branch_taken_i   datapath branch condition (EXE)
//   next_state_o     phase to enter on the next edge
//   retire_o         the current phase completes an instruction
//   *_o strobes      datapath controls, see top-level header
// ----------------------------------------------------------------------------
module micro_next_state
    import micro_sequencer_pkg::*;
(
    input  logic [2:0]  state_i,
    input  logic        reset_i,
    input  logic [31:0] micro_instruct_i,
    input  logic [31:0] uq_i,
    input  logic        branch_taken_i,
    output logic [2:0]  next_state_o,
    output logic        retire_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_out_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        halted_o
);

    // Operand fields and unused control bits are the datapath's business.
    logic unused_fields_s;
    assign unused_fields_s = ^{micro_instruct_i[30:9], micro_instruct_i[7],
                               micro_instruct_i[5:0], uq_i[31], uq_i[28:8],
                               uq_i[6], uq_i[1:0]};

    // Next-phase selection and retire detection.
    always_comb begin
        next_state_o = ST_IF;
        retire_o     = 1'b0;
        case (state_i)
            ST_IF: begin
                next_state_o = ST_ID;
            end
            ST_ID: begin
                // Halt has priority over jump; halt is never counted.
                if (micro_instruct_i[UI_HALT]) begin
                    next_state_o = ST_HALT;
                end else if (micro_instruct_i[UI_JUMP]) begin
                    retire_o = 1'b1;
                end else if (micro_instruct_i[UI_ALU_USE]) begin
                    next_state_o = ST_EXE;
                end else begin
                    // All-zero or unrecognised word retires as a nop.
                    retire_o = 1'b1;
                end
            end
            ST_EXE: begin
                if (uq_i[UI_BRANCH]) begin
                    retire_o = 1'b1;
                end else if (uq_i[UI_MEM_ACC]) begin
                    next_state_o = ST_MEM;
                end else if (uq_i[UI_WB_USE]) begin
                    next_state_o = ST_WB;
                end else begin
                    retire_o = 1'b1;
                end
            end
            ST_MEM: begin
                if (uq_i[UI_MEM_WRITE]) begin
                    retire_o = 1'b1;
                end else if (uq_i[UI_MEM_READ]) begin
                    next_state_o = ST_WB;
                end else begin
                    retire_o = 1'b1;
                end
            end
            ST_WB: begin
                retire_o = 1'b1;
            end
            ST_HALT: begin
                next_state_o = ST_HALT;
            end
            default: begin
                // Encodings 6 and 7 recover to IF.
                next_state_o = ST_IF;
            end
        endcase
    end

    // Per-phase datapath strobes; all inactive while reset is held.
    always_comb begin
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_src_o        = PCSRC_SEQ;
        alu_out_write_o = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        halted_o        = 1'b0;
        if (reset_i) begin
            halted_o = 1'b0;
        end else begin
            case (state_i)
                ST_IF: begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    pc_src_o   = PCSRC_SEQ;
                end
                ST_ID: begin
                    // A halt word must not move the PC even if jump is set.
                    if (!micro_instruct_i[UI_HALT] && micro_instruct_i[UI_JUMP]) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = PCSRC_JUMP;
                    end else begin
                        pc_write_o = 1'b0;
                    end
                end
                ST_EXE: begin
                    alu_out_write_o = 1'b1;
                    if (uq_i[UI_BRANCH]) begin
                        pc_write_o = branch_taken_i;
                        pc_src_o   = PCSRC_BRANCH;
                    end else begin
                        pc_write_o = 1'b0;
                    end
                end
                ST_MEM: begin
                    if (uq_i[UI_MEM_WRITE]) begin
                        mem_write_o = 1'b1;
                    end else if (uq_i[UI_MEM_READ]) begin
                        mem_read_o = 1'b1;
                    end else begin
                        mem_write_o = 1'b0;
                    end
                end
                ST_WB: begin
                    reg_write_o  = uq_i[UI_REG_WRITE];
                    mem_to_reg_o = uq_i[UI_MEM2REG];
                end
                ST_HALT: begin
                    halted_o = 1'b1;
                end
                default: begin
                    halted_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// ----------------------------------------------------------------------------
// micro_sequencer
// Multi-cycle phase sequencer (IF/ID/EXE/MEM/WB/HALT) between the decoder and
// the datapath. Holds the phase register, the latched microinstruction and
// the saturating retired-instruction counter.
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   MicroInstruct         decoded microinstruction (sampled in ID)
//   BranchTaken           branch condition (EXE)
//   State                 current phase (IF=0 .. HALT=5)
//   IRWrite, PCWrite      instruction register / PC load
//   PCSrc                 00 PC+4, 01 branch, 10 jump
//   ALUOutWrite           ALU result latch
//   MemRead, MemWrite     data memory strobes
//   RegWrite, MemToReg    register write-back and its source
//   Halted                high in HALT
//   InstrCount            retired instructions, saturating
// ----------------------------------------------------------------------------
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [31:0]        MicroInstruct,
    input  logic               BranchTaken,
    output logic [2:0]         State,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               ALUOutWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               MemToReg,
    output logic               Halted,
    output logic [COUNT_W-1:0] InstrCount
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [31:0]        uq_q;
    logic [31:0]        uq_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               retire_s;

    micro_next_state u_next_state (
        .state_i          (state_q),
        .reset_i          (Reset),
        .micro_instruct_i (MicroInstruct),
        .uq_i             (uq_q),
        .branch_taken_i   (BranchTaken),
        .next_state_o     (state_d),
        .retire_o         (retire_s),
        .ir_write_o       (IRWrite),
        .pc_write_o       (PCWrite),
        .pc_src_o         (PCSrc),
        .alu_out_write_o  (ALUOutWrite),
        .mem_read_o       (MemRead),
        .mem_write_o      (MemWrite),
        .reg_write_o      (RegWrite),
        .mem_to_reg_o     (MemToReg),
        .halted_o         (Halted)
    );

    // Latch the microinstruction when leaving ID; later phases decode only uq.
    always_comb begin
        if (state_q == ST_ID) begin
            uq_d = MicroInstruct;
        end else begin
            uq_d = uq_q;
        end
    end

    // Saturating retire counter.
    always_comb begin
        if (retire_s && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State, latched microinstruction and counter registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IF;
            uq_q    <= 32'h0000_0000;
            count_q <= {COUNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            uq_q    <= uq_d;
            count_q <= count_d;
        end
    end

    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Multi-cycle phase sequencer that consumes the 32-bit microinstruction produced by the instruction decoder.
It steps each instruction through the IF/ID/EXE/MEM/WB phases and issues per-phase datapath strobes and PC control.
It counts retired instructions and parks in HALT on a halt microinstruction.
It sits between the decoder and the datapath of the multi-cycle CPU.

Parameters:
COUNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
CLK  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
MicroInstruct  input  32  decoded microinstruction; valid during ID
BranchTaken  input  1  datapath branch condition; valid during EXE
State  output  3  IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5
IRWrite  output  1  load the instruction register
PCWrite  output  1  load the PC
PCSrc  output  2  00=PC+4, 01=branch target, 10=jump target
ALUOutWrite  output  1  latch the ALU result
MemRead  output  1  data-memory read strobe
MemWrite  output  1  data-memory write strobe
RegWrite  output  1  register-file write strobe
MemToReg  output  1  write-back source: 1=memory, 0=ALU
Halted  output  1  high while in HALT
InstrCount  output  COUNT_W  retired-instruction count

Behaviour:
- Microinstruction fields (fixed):
  - [31] ALU use; [30] memory access; [29] register write-back.
  - [28:25] ALU op; [24:20] rs; [19:15] rt; [14:10] rd.
  - [0] ALU B from register; [1] immediate; [2] RegWrite; [3] MemToReg.
  - [4] MemWrite; [5] MemRead; [6] jump; [7] branch; [8] halt.
- Reset (synchronous):
  - State <= IF, uq <= 0, InstrCount <= 0.
  - While Reset is high, all strobes are forced 0, PCSrc=00 and Halted=0, whatever the state.
- uq: internal 32-bit register loaded from MicroInstruct on the ID->next edge. EXE, MEM and WB decode uq only.
- Strobes are combinational from State and uq (from MicroInstruct in ID). Any strobe not listed for a state is 0.
- IF:
  - IRWrite=1, PCWrite=1, PCSrc=00.
  - Next state ID.
- ID (priority order):
  - halt: go to HALT.
  - else jump: PCWrite=1, PCSrc=10, retire, go to IF.
  - else [31]: go to EXE.
  - else (all-zero or unknown microinstruction): retire as a nop, go to IF.
- EXE:
  - ALUOutWrite=1.
  - If branch: PCWrite=BranchTaken, PCSrc=01, retire, go to IF.
  - Else if [30]: go to MEM.
  - Else if [29]: go to WB.
  - Else retire, go to IF.
- MEM:
  - If [4]: MemWrite=1, retire, go to IF.
  - Else if [5]: MemRead=1, go to WB.
  - Else retire, go to IF.
- WB:
  - RegWrite=uq[2], MemToReg=uq[3].
  - Retire, go to IF.
- HALT:
  - Halted=1; all other strobes 0.
  - Stays in HALT until Reset. A halt is not counted as retired.
- Retire: InstrCount increments by 1 on the edge that leaves the retiring state. It saturates at 2^COUNT_W-1 and does not wrap.
- Instruction latency in cycles: j=2, beq/bgtz=3, R-type/addi/andi/ori/sw/sll=4, lw=5.
- Reset mid-instruction: the in-flight instruction is abandoned and not counted; IF is the next state.
- Invalid State encodings (6, 7): next state IF.

Decomposition:
- Shared package: state encodings, microinstruction bit indices and field ranges, PCSrc encodings. The decoder uses the same package.
- Natural sub-module: micro_next_state, the combinational next-state and strobe logic. The top holds State, uq and the counter.

Test Plan:
- add, MicroInstruct=0xA4110C05 held from ID:
  - State 0,1,2,4,0.
  - RegWrite=1 and MemToReg=0 in WB only; MemRead and MemWrite never assert.
  - InstrCount 0 -> 1.
- lw=0xE400002E: 5 cycles; MemRead in MEM; RegWrite=1 with MemToReg=1 in WB.
- sw=0xC4000010: State 0,1,2,3,0; MemWrite for exactly one cycle; RegWrite never asserts.
- beq=0x8C000081:
  - BranchTaken=1: PCWrite=1 and PCSrc=01 in EXE.
  - BranchTaken=0: PCWrite=0 in EXE.
  - Both cases: 3 cycles, InstrCount +1.
- j=0x00000040 then halt=0x00000100:
  - j: PCWrite=1 and PCSrc=10 in ID, 2 cycles.
  - halt: Halted=1 and held for 10 cycles; InstrCount stays at 1.
  - Reset pulse: State=0, InstrCount=0, Halted=0.
- COUNT_W=2: five nops (0x00000000) give InstrCount 1,2,3,3,3. Reset asserted during EXE of an add gives IF next, no RegWrite, and no count.
